// File: rtl/keypad_pkg.sv
// Shared types and constants for the 4x4 keypad scanner/encoder.
// Keymap is indexed [row][column]; rows and columns are active-low.
package keypad_pkg;

    typedef enum logic [1:0] {
        SCAN,
        DEBOUNCE,
        PRESSED,
        RELEASE
    } kp_state_t;

    localparam logic [3:0] ROWS_IDLE = 4'b1111;
    localparam logic [3:0] COL_RESET = 4'b1110;

    localparam logic [3:0] KEYMAP [4][4] = '{
        '{4'h1, 4'h2, 4'h3, 4'hA},
        '{4'h4, 4'h5, 4'h6, 4'hB},
        '{4'h7, 4'h8, 4'h9, 4'hC},
        '{4'hE, 4'h0, 4'hF, 4'hD}
    };

    function automatic logic one_low(input logic [3:0] v);
        unique case (v)
            4'b1110, 4'b1101, 4'b1011, 4'b0111: return 1'b1;
            default:                            return 1'b0;
        endcase
    endfunction

    function automatic logic [1:0] low_index(input logic [3:0] v);
        unique case (v)
            4'b1101: return 2'd1;
            4'b1011: return 2'd2;
            4'b0111: return 2'd3;
            default: return 2'd0;
        endcase
    endfunction

endpackage

// File: rtl/keypad_sync.sv
// Two-flop synchroniser for the asynchronous keypad row inputs.
// Resets to all-ones so the rows read as idle out of reset.
module keypad_sync (
    input  logic       clk,
    input  logic       rst,
    input  logic [3:0] d,
    output logic [3:0] q
);

    logic [3:0] meta;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            meta <= 4'b1111;
            q    <= 4'b1111;
        end else begin
            meta <= d;
            q    <= meta;
        end
    end

endmodule

// File: rtl/keypad_scan_encoder.sv
// 4x4 keypad column scanner with debounce and hex encoding.
// Define KEYPAD_AUTOREPEAT_EN to add auto-repeat strobes while a key is held.
module keypad_scan_encoder
    import keypad_pkg::*;
#(
    parameter int SCAN_DIV     = 1000,
    parameter int DEBOUNCE_CYC = 50000,
    parameter int REPEAT_DELAY = 25000000,
    parameter int REPEAT_RATE  = 5000000
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [3:0] fil,
    output logic [3:0] col,
    output logic [3:0] key_code,
    output logic       key_valid,
    output logic       key_held
);

    localparam int DW = $clog2(SCAN_DIV);
    localparam int BW = $clog2(DEBOUNCE_CYC);
    localparam logic [DW-1:0] DWELL_MAX = DW'(SCAN_DIV - 1);
    localparam logic [BW-1:0] DEB_MAX   = BW'(DEBOUNCE_CYC - 1);

    if (SCAN_DIV < 4 || DEBOUNCE_CYC < 2 ||
        REPEAT_DELAY < 1 || REPEAT_RATE < 1) begin : g_bad_param
        $error("keypad_scan_encoder: illegal parameter value");
    end

    kp_state_t     state, state_n;
    logic [3:0]    fil_s;
    logic [3:0]    col_n, code_n, cand_pat;
    logic [DW-1:0] dwell, dwell_n;
    logic [BW-1:0] deb, deb_n;
    logic [1:0]    cand_row, cand_row_n;
    logic [1:0]    cand_col, cand_col_n;
    logic          valid_n, held_n;
    logic [3:0]    col_next;

`ifdef KEYPAD_AUTOREPEAT_EN
    localparam int RMAX = (REPEAT_DELAY > REPEAT_RATE) ? REPEAT_DELAY : REPEAT_RATE;
    localparam int RW   = (RMAX > 1) ? $clog2(RMAX) : 1;
    logic [RW-1:0] rep, rep_n, rep_lim;
    logic          rep_fast, rep_fast_n;
    assign rep_lim = rep_fast ? RW'(REPEAT_RATE - 1) : RW'(REPEAT_DELAY - 1);
`endif

    keypad_sync u_sync (
        .clk (clk),
        .rst (rst),
        .d   (fil),
        .q   (fil_s)
    );

    assign col_next = {col[2:0], col[3]};
    assign cand_pat = ~(4'b0001 << cand_row);

    always_comb begin
        state_n    = state;
        col_n      = col;
        dwell_n    = dwell;
        deb_n      = deb;
        cand_row_n = cand_row;
        cand_col_n = cand_col;
        code_n     = key_code;
        valid_n    = 1'b0;
        held_n     = key_held;
`ifdef KEYPAD_AUTOREPEAT_EN
        rep_n      = rep;
        rep_fast_n = rep_fast;
`endif
        unique case (state)
            SCAN: begin
                if (dwell == DWELL_MAX) begin
                    dwell_n = '0;
                    if (one_low(fil_s)) begin
                        cand_row_n = low_index(fil_s);
                        cand_col_n = low_index(col);
                        deb_n      = '0;
                        state_n    = DEBOUNCE;
                    end else begin
                        col_n = col_next;
                    end
                end else begin
                    dwell_n = dwell + 1'b1;
                end
            end
            DEBOUNCE: begin
                if (fil_s == cand_pat) begin
                    if (deb == DEB_MAX) begin
                        state_n = PRESSED;
                        code_n  = KEYMAP[cand_row][cand_col];
                        valid_n = 1'b1;
                        held_n  = 1'b1;
`ifdef KEYPAD_AUTOREPEAT_EN
                        rep_n      = '0;
                        rep_fast_n = 1'b0;
`endif
                    end else begin
                        deb_n = deb + 1'b1;
                    end
                end else begin
                    state_n = SCAN;
                    col_n   = col_next;
                    dwell_n = '0;
                end
            end
            PRESSED: begin
                if (fil_s == ROWS_IDLE) begin
                    deb_n   = '0;
                    state_n = RELEASE;
                end else begin
`ifdef KEYPAD_AUTOREPEAT_EN
                    if (rep == rep_lim) begin
                        valid_n    = 1'b1;
                        rep_n      = '0;
                        rep_fast_n = 1'b1;
                    end else begin
                        rep_n = rep + 1'b1;
                    end
`endif
                end
            end
            RELEASE: begin
                if (fil_s == ROWS_IDLE) begin
                    if (deb == DEB_MAX) begin
                        held_n  = 1'b0;
                        state_n = SCAN;
                        col_n   = col_next;
                        dwell_n = '0;
                        deb_n   = '0;
`ifdef KEYPAD_AUTOREPEAT_EN
                        rep_n      = '0;
                        rep_fast_n = 1'b0;
`endif
                    end else begin
                        deb_n = deb + 1'b1;
                    end
                end else begin
                    deb_n   = '0;
                    state_n = PRESSED;
                end
            end
            default: state_n = SCAN;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state     <= SCAN;
            col       <= COL_RESET;
            dwell     <= '0;
            deb       <= '0;
            cand_row  <= '0;
            cand_col  <= '0;
            key_code  <= 4'h0;
            key_valid <= 1'b0;
            key_held  <= 1'b0;
        end else begin
            state     <= state_n;
            col       <= col_n;
            dwell     <= dwell_n;
            deb       <= deb_n;
            cand_row  <= cand_row_n;
            cand_col  <= cand_col_n;
            key_code  <= code_n;
            key_valid <= valid_n;
            key_held  <= held_n;
        end
    end

`ifdef KEYPAD_AUTOREPEAT_EN
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            rep      <= '0;
            rep_fast <= 1'b0;
        end else begin
            rep      <= rep_n;
            rep_fast <= rep_fast_n;
        end
    end
`endif

endmodule

// File: tb/tb_keypad_scan_encoder.sv
// Directed bench: a keypad matrix model drives the rows from the scanned
// column; expected key codes are queued when a press is driven.
module tb_keypad_scan_encoder;

    logic       clk = 1'b0;
    logic       rst = 1'b0;
    logic [3:0] fil;
    logic [3:0] col;
    logic [3:0] key_code;
    logic       key_valid;
    logic       key_held;

    logic [3:0] keys [4];
    logic [3:0] exp_q [$];
    int         st_q [$];
    logic [3:0] prev_code;
    logic [3:0] col_seq [4];
    int total   = 0;
    int bad     = 0;
    int strobes = 0;
    int cyc     = 0;

    keypad_scan_encoder #(
        .SCAN_DIV     (4),
        .DEBOUNCE_CYC (8),
        .REPEAT_DELAY (40),
        .REPEAT_RATE  (16)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .fil       (fil),
        .col       (col),
        .key_code  (key_code),
        .key_valid (key_valid),
        .key_held  (key_held)
    );

    always #5 clk = ~clk;

    // Row i pulls low when a key in row i sits on the driven column.
    always_comb begin
        fil = 4'b1111;
        for (int i = 0; i < 4; i++)
            fil[i] = ~|(keys[i] & ~col);
    end

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic step(input int n);
        logic [3:0] e;
        for (int i = 0; i < n; i++) begin
            @(negedge clk);
            cyc++;
            if (key_valid === 1'b1) begin
                strobes++;
                st_q.push_back(cyc);
                chk("strobe_expected", 32'(exp_q.size() != 0), 1);
                if (exp_q.size() != 0) begin
                    e = exp_q.pop_front();
                    chk("key_code", 32'(key_code), 32'(e));
                end
            end
            if (!rst) begin
                prev_code = key_code;
            end else if (key_code !== prev_code) begin
                chk("code_change_on_strobe", 32'(key_valid), 1);
                prev_code = key_code;
            end
        end
    endtask

    task automatic wait_accept(input string tag);
        int s0;
        int n;
        s0 = strobes;
        n = 0;
        while (strobes == s0 && n < 26) begin
            step(1);
            n++;
        end
        chk(tag, 32'(strobes != s0), 1);
    endtask

    task automatic release_all();
        for (int i = 0; i < 4; i++) keys[i] = 4'b0000;
    endtask

    initial begin
        int s0;
        int changes;
        logic [3:0] c0;
        col_seq = '{4'b1110, 4'b1101, 4'b1011, 4'b0111};
        release_all();
        prev_code = 4'h0;

        // reset state
        step(2);
        #1;
        chk("rst_col", 32'(col), 32'hE);
        chk("rst_code", 32'(key_code), 0);
        chk("rst_valid", 32'(key_valid), 0);
        chk("rst_held", 32'(key_held), 0);
        @(negedge clk);
        rst = 1'b1;

        // idle scanning
        for (int k = 0; k < 16; k++) begin
            chk("idle_col", 32'(col), 32'(col_seq[k % 4]));
            step(4);
        end
        chk("idle_strobes", strobes, 0);
        chk("idle_code", 32'(key_code), 0);

        // press '5' (row1, col1)
        s0 = strobes;
        exp_q.push_back(4'h5);
        keys[1] = 4'b0010;
        wait_accept("accept_5");
        chk("held_5", 32'(key_held), 1);
        step(30);
        release_all();
        step(8);
        chk("held_during_release", 32'(key_held), 1);
        step(4);
        chk("held_after_release", 32'(key_held), 0);
        chk("col_after_release", 32'(col), 32'hB);
        chk("strobes_5", strobes - s0, 1);

        // 3-cycle glitch press
        s0 = strobes;
        keys[1] = 4'b0010;
        step(3);
        release_all();
        step(40);
        chk("glitch_strobes", strobes - s0, 0);
        chk("glitch_held", 32'(key_held), 0);

        // '#', '*', 'D', '0' on row 3
        s0 = strobes;
        exp_q.push_back(4'hF);
        keys[3] = 4'b0100;
        wait_accept("accept_hash");
        step(10);
        release_all();
        step(30);
        exp_q.push_back(4'hE);
        keys[3] = 4'b0001;
        wait_accept("accept_star");
        step(10);
        release_all();
        step(30);
        exp_q.push_back(4'hD);
        keys[3] = 4'b1000;
        wait_accept("accept_d");
        step(10);
        release_all();
        step(30);
        exp_q.push_back(4'h0);
        keys[3] = 4'b0010;
        wait_accept("accept_0");
        chk("code_0", 32'(key_code), 0);
        step(10);
        release_all();
        step(30);
        chk("seq_strobes", strobes - s0, 4);

        // ghost: rows 0 and 2 on column 0
        s0 = strobes;
        changes = 0;
        keys[0] = 4'b0001;
        keys[2] = 4'b0001;
        step(4);
        for (int k = 0; k < 32; k++) begin
            c0 = col;
            step(1);
            if (col !== c0) changes++;
            chk("ghost_col_onehot", 32'($countones(~col)), 1);
        end
        release_all();
        chk("ghost_rotations", changes, 8);
        chk("ghost_strobes", strobes - s0, 0);
        step(10);

        // hold 'A' (row0, col3)
        s0 = strobes;
        st_q.delete();
        exp_q.push_back(4'hA);
`ifdef KEYPAD_AUTOREPEAT_EN
        exp_q.push_back(4'hA);
        exp_q.push_back(4'hA);
`endif
        keys[0] = 4'b1000;
        wait_accept("accept_a");
        step(60);
        release_all();
        step(30);
`ifdef KEYPAD_AUTOREPEAT_EN
        chk("repeat_strobes", strobes - s0, 3);
        if (st_q.size() == 3) begin
            chk("repeat_delay", st_q[1] - st_q[0], 40);
            chk("repeat_rate", st_q[2] - st_q[1], 16);
        end
`else
        chk("single_strobe", strobes - s0, 1);
`endif
        chk("held_a_released", 32'(key_held), 0);

        // reset during hold, then fresh accept
        s0 = strobes;
        exp_q.push_back(4'hA);
        keys[0] = 4'b1000;
        step(30);
        chk("pre_reset_strobes", strobes - s0, 1);
        chk("pre_reset_held", 32'(key_held), 1);
        rst = 1'b0;
        #1;
        chk("mid_rst_col", 32'(col), 32'hE);
        chk("mid_rst_code", 32'(key_code), 0);
        chk("mid_rst_valid", 32'(key_valid), 0);
        chk("mid_rst_held", 32'(key_held), 0);
        step(3);
        rst = 1'b1;
        exp_q.push_back(4'hA);
        wait_accept("fresh_accept");
        chk("fresh_code", 32'(key_code), 32'hA);
        release_all();
        step(30);
        chk("fresh_released", 32'(key_held), 0);
        chk("queue_drained", 32'(exp_q.size()), 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
